// File: rtl/jam_pkg.sv
// ---------------------------------------------------------------------------
// jam_pkg : shared types and sizing helpers for the jam_perm_search engine.
// ---------------------------------------------------------------------------
`default_nettype none

package jam_pkg;

  // Search controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_EVAL  = 3'd2,
    ST_PIVOT = 3'd3,
    ST_SWAP  = 3'd4,
    ST_REV   = 3'd5,
    ST_DONE  = 3'd6
  } jam_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int jam_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Index width: enough bits for 0..n-1, never less than one bit.
  function automatic int jam_iw(input int n);
    return (jam_clog2(n) < 1) ? 1 : jam_clog2(n);
  endfunction

  // Total-cost width: n words of cw bits summed without overflow.
  function automatic int jam_sw(input int n, input int cw);
    return cw + jam_clog2(n);
  endfunction

  // Default engine sizing.
  localparam int JAM_N_DEF   = 8;
  localparam int JAM_CW_DEF  = 7;
  localparam int JAM_MCW_DEF = 16;
  localparam int JAM_IW_DEF  = jam_iw(JAM_N_DEF);
  localparam int JAM_SW_DEF  = jam_sw(JAM_N_DEF, JAM_CW_DEF);

endpackage

`default_nettype wire

// File: rtl/jam_perm_next.sv
// ---------------------------------------------------------------------------
// jam_perm_next : permutation register with lexicographic next-permutation
//                 steps (init / pivot / swap / reverse), one step per strobe.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jam_perm_next import jam_pkg::*; #(
  parameter int N  = JAM_N_DEF,
  parameter int IW = jam_iw(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            init_i,
  input  logic            pivot_i,
  input  logic            swap_i,
  input  logic            rev_i,
  output logic [N*IW-1:0] perm_o,
  output logic            last_o
);

  logic [IW-1:0] perm_q [N];
  logic [IW-1:0] perm_d [N];
  logic [IW-1:0] ident_w [N];
  logic [IW-1:0] p_q;
  logic [IW-1:0] p_find_w;
  logic [IW-1:0] q_find_w;

  for (genvar k = 0; k < N; k++) begin : g_ident
    assign ident_w[k]          = IW'(k);
    assign perm_o[k*IW +: IW]  = perm_q[k];
  end

  // Pivot: largest p with perm[p] < perm[p+1]; later hits override earlier.
  always_comb begin
    p_find_w = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) p_find_w = IW'(i);
    end
  end

  // Swap partner: largest q beyond the pivot whose value exceeds perm[p].
  always_comb begin
    q_find_w = p_q;
    for (int i = 0; i < N; i++) begin
      if ((IW'(i) > p_q) && (perm_q[i] > perm_q[p_q])) q_find_w = IW'(i);
    end
  end

  // Final permutation is strictly descending.
  always_comb begin
    last_o = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      if (!(perm_q[i] > perm_q[i+1])) last_o = 1'b0;
    end
  end

  // Next permutation contents for the active strobe.
  always_comb begin
    int j;
    j      = 0;
    perm_d = perm_q;
    if (init_i) begin
      perm_d = ident_w;
    end else if (swap_i) begin
      perm_d[p_q]      = perm_q[q_find_w];
      perm_d[q_find_w] = perm_q[p_q];
    end else if (rev_i) begin
      // Mirror the tail p+1..N-1 around its centre.
      for (int i = 0; i < N; i++) begin
        if (IW'(i) > p_q) begin
          j         = N + int'(p_q) - i;
          perm_d[i] = perm_q[IW'(j)];
        end
      end
    end
  end

  // Permutation and pivot registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perm_q <= ident_w;
      p_q    <= '0;
    end else begin
      perm_q <= perm_d;
      if (pivot_i) p_q <= p_find_w;
    end
  end

endmodule

`default_nettype wire

// File: rtl/jam_perm_search.sv
// ---------------------------------------------------------------------------
// jam_perm_search : exhaustive N-job / N-worker assignment search.
//                   Walks all permutations in lexicographic order, sums the
//                   table costs and keeps the best total, its multiplicity
//                   and the first permutation reaching it.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jam_perm_search import jam_pkg::*; #(
  parameter int N   = JAM_N_DEF,
  parameter int CW  = JAM_CW_DEF,
  parameter int MCW = JAM_MCW_DEF,
  parameter int IW  = jam_iw(N),
  parameter int SW  = jam_sw(N, CW)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            Start,
  input  logic            Mode,
  input  logic [CW-1:0]   Cost,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  output logic            Busy,
  output logic            Valid,
  output logic [SW-1:0]   MinCost,
  output logic [MCW-1:0]  MatchCount,
  output logic [N*IW-1:0] BestPerm
);

  jam_state_e      state_q, state_d;
  logic            mode_q, mode_d;
  logic            first_q, first_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [IW-1:0]   w_q, w_d;
  logic [IW-1:0]   j_q, j_d;
  logic [SW-1:0]   min_q, min_d;
  logic [MCW-1:0]  cnt_q, cnt_d;
  logic [N*IW-1:0] best_q, best_d;

  logic            init_s, pivot_s, swap_s, rev_s;
  logic            last_perm_w;
  logic            last_k_w;
  logic            better_w;
  logic [N*IW-1:0] perm_w;
  logic [IW-1:0]   perm_a [N];

  jam_perm_next #(
    .N  (N),
    .IW (IW)
  ) u_perm (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .init_i  (init_s),
    .pivot_i (pivot_s),
    .swap_i  (swap_s),
    .rev_i   (rev_s),
    .perm_o  (perm_w),
    .last_o  (last_perm_w)
  );

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign perm_a[k] = perm_w[k*IW +: IW];
  end

  assign last_k_w = (w_q == IW'(N - 1));
  assign better_w = mode_q ? (acc_q > min_q) : (acc_q < min_q);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing: N accumulate cycles, evaluate, then three steps
  // to advance the permutation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Start) state_d = ST_ACCUM;
      ST_ACCUM: if (last_k_w) state_d = ST_EVAL;
      ST_EVAL:  state_d = last_perm_w ? ST_DONE : ST_PIVOT;
      ST_PIVOT: state_d = ST_SWAP;
      ST_SWAP:  state_d = ST_REV;
      ST_REV:   state_d = ST_ACCUM;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded status and permutation strobes.
  always_comb begin
    Busy    = (state_q != ST_IDLE);
    Valid   = (state_q == ST_DONE);
    init_s  = (state_q == ST_IDLE) && Start;
    pivot_s = (state_q == ST_PIVOT);
    swap_s  = (state_q == ST_SWAP);
    rev_s   = (state_q == ST_REV);
  end

  // Datapath next values: addressing, accumulation and best-result update.
  always_comb begin
    mode_d  = mode_q;
    first_d = first_q;
    acc_d   = acc_q;
    w_d     = w_q;
    j_d     = j_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          mode_d  = Mode;
          first_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          w_d     = '0;
          j_d     = '0;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_q + SW'(Cost);
        if (last_k_w) begin
          w_d = '0;
          j_d = '0;
        end else begin
          w_d = w_q + IW'(1);
          j_d = perm_a[w_q + IW'(1)];
        end
      end
      ST_EVAL: begin
        first_d = 1'b0;
        acc_d   = '0;
        if (first_q || better_w) begin
          min_d  = acc_q;
          cnt_d  = MCW'(1);
          best_d = perm_w;
        end else if (acc_q == min_q) begin
          cnt_d = cnt_q + MCW'(1);
        end
      end
      ST_REV: begin
        // The reversed tail never includes index 0, so perm[0] is already
        // final during this cycle.
        w_d = '0;
        j_d = perm_a[0];
      end
      default: begin
      end
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q  <= 1'b0;
      first_q <= 1'b0;
      acc_q   <= '0;
      w_q     <= '0;
      j_q     <= '0;
      min_q   <= '0;
      cnt_q   <= '0;
      best_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      first_q <= first_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      j_q     <= j_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      best_q  <= best_d;
    end
  end

  assign W          = w_q;
  assign J          = j_q;
  assign MinCost    = min_q;
  assign MatchCount = cnt_q;
  assign BestPerm   = best_q;

endmodule

`default_nettype wire
